// File: rtl/partial_fm_scheduler.sv
// Sequences the partial feature-map engine over IN_CH channels and accumulates three saturated Q1.15 maps.
// Optional watchdog on the RUN wait is enabled by defining SCHED_TIMEOUT_EN.
module partial_fm_scheduler #(
    parameter int OP_SIZE = 4,
    parameter int IN_CH   = 3,
    parameter int CH_W    = 2,
    parameter int ACC_W   = 18,
    parameter int TIMEOUT = 256
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          start,
    output logic                          busy,
    output logic [CH_W-1:0]               ch_sel,
    output logic                          eng_rst,
    input  logic                          eng_done,
    input  logic [16*OP_SIZE*OP_SIZE-1:0] eng_ik1,
    input  logic [16*OP_SIZE*OP_SIZE-1:0] eng_ik2,
    input  logic [16*OP_SIZE*OP_SIZE-1:0] eng_ik3,
    output logic [16*OP_SIZE*OP_SIZE-1:0] fm1,
    output logic [16*OP_SIZE*OP_SIZE-1:0] fm2,
    output logic [16*OP_SIZE*OP_SIZE-1:0] fm3,
    output logic                          fm_valid,
    input  logic                          fm_ready,
    output logic                          err
);

    localparam int N  = OP_SIZE * OP_SIZE;
    localparam int KW = (N > 1) ? $clog2(N) : 1;
    localparam logic signed [ACC_W-1:0] MAXV = ACC_W'(32767);
    localparam logic signed [ACC_W-1:0] MINV = -ACC_W'(32768);

    if ((2 ** CH_W) < IN_CH || ACC_W < 16 + $clog2(IN_CH) || TIMEOUT < 1) begin : g_param_check
        $error("partial_fm_scheduler: illegal parameter combination");
    end

    typedef enum logic [2:0] {S_IDLE, S_RUN, S_ACCUM, S_NEXT, S_DONE} state_t;

    state_t                  r_state;
    logic                    r_busy;
    logic [CH_W-1:0]         r_ch_sel;
    logic                    r_eng_rst;
    logic                    r_fm_valid;
    logic                    r_err;
    logic [KW-1:0]           r_k;
    logic signed [ACC_W-1:0] r_acc1 [N];
    logic signed [ACC_W-1:0] r_acc2 [N];
    logic signed [ACC_W-1:0] r_acc3 [N];

`ifdef SCHED_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT + 1);
    logic [WD_W-1:0]         r_wd;
`endif

    logic [15:0]      w_e1, w_e2, w_e3;
    logic [ACC_W-1:0] w_sum1, w_sum2, w_sum3;
    logic             w_first_ch;
    logic             w_last_k;
    logic             w_last_ch;

    // Channel 0 discards prior contents, so every schedule starts from clean sums.
    always_comb begin
        w_first_ch = (r_ch_sel == '0);
        w_last_k   = (r_k == KW'(N - 1));
        w_last_ch  = (r_ch_sel == CH_W'(IN_CH - 1));
        w_e1       = eng_ik1[16*r_k +: 16];
        w_e2       = eng_ik2[16*r_k +: 16];
        w_e3       = eng_ik3[16*r_k +: 16];
        w_sum1     = (w_first_ch ? '0 : r_acc1[r_k]) + {{(ACC_W-16){w_e1[15]}}, w_e1};
        w_sum2     = (w_first_ch ? '0 : r_acc2[r_k]) + {{(ACC_W-16){w_e2[15]}}, w_e2};
        w_sum3     = (w_first_ch ? '0 : r_acc3[r_k]) + {{(ACC_W-16){w_e3[15]}}, w_e3};
    end

    function automatic logic [15:0] sat16(input logic signed [ACC_W-1:0] a);
        if (a > MAXV)      return 16'h7FFF;
        else if (a < MINV) return 16'h8000;
        else               return a[15:0];
    endfunction

    always_comb begin
        fm1 = '0;
        fm2 = '0;
        fm3 = '0;
        for (int unsigned i = 0; i < N; i++) begin
            fm1[16*i +: 16] = sat16(r_acc1[i]);
            fm2[16*i +: 16] = sat16(r_acc2[i]);
            fm3[16*i +: 16] = sat16(r_acc3[i]);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_busy     <= 1'b0;
            r_ch_sel   <= '0;
            r_eng_rst  <= 1'b1;
            r_fm_valid <= 1'b0;
            r_err      <= 1'b0;
            r_k        <= '0;
`ifdef SCHED_TIMEOUT_EN
            r_wd       <= '0;
`endif
            for (int unsigned i = 0; i < N; i++) begin
                r_acc1[i] <= '0;
                r_acc2[i] <= '0;
                r_acc3[i] <= '0;
            end
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_eng_rst <= 1'b1;
                    if (start) begin
                        r_busy    <= 1'b1;
                        r_ch_sel  <= '0;
                        r_err     <= 1'b0;
                        r_eng_rst <= 1'b0;
`ifdef SCHED_TIMEOUT_EN
                        r_wd      <= '0;
`endif
                        r_state   <= S_RUN;
                    end
                end
                S_RUN: begin
                    if (eng_done) begin
                        r_k     <= '0;
                        r_state <= S_ACCUM;
                    end
`ifdef SCHED_TIMEOUT_EN
                    else if (r_wd == WD_W'(TIMEOUT - 1)) begin
                        r_err     <= 1'b1;
                        r_busy    <= 1'b0;
                        r_eng_rst <= 1'b1;
                        r_state   <= S_IDLE;
                    end else begin
                        r_wd <= r_wd + 1'b1;
                    end
`endif
                end
                S_ACCUM: begin
                    r_acc1[r_k] <= w_sum1;
                    r_acc2[r_k] <= w_sum2;
                    r_acc3[r_k] <= w_sum3;
                    r_k         <= r_k + 1'b1;
                    if (w_last_k) begin
                        if (w_last_ch) begin
                            r_fm_valid <= 1'b1;
                            r_state    <= S_DONE;
                        end else begin
                            r_eng_rst <= 1'b1;
                            r_state   <= S_NEXT;
                        end
                    end
                end
                S_NEXT: begin
                    r_ch_sel  <= r_ch_sel + 1'b1;
                    r_eng_rst <= 1'b0;
`ifdef SCHED_TIMEOUT_EN
                    r_wd      <= '0;
`endif
                    r_state   <= S_RUN;
                end
                S_DONE: begin
                    if (fm_ready) begin
                        r_fm_valid <= 1'b0;
                        r_busy     <= 1'b0;
                        r_eng_rst  <= 1'b1;
                        r_state    <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign busy     = r_busy;
    assign ch_sel   = r_ch_sel;
    assign eng_rst  = r_eng_rst;
    assign fm_valid = r_fm_valid;
    assign err      = r_err;

endmodule

// File: tb/tb_partial_fm_scheduler.sv
// Bench for partial_fm_scheduler: behavioural engine, table-driven partial maps, reference sums with saturation.
module tb_partial_fm_scheduler;

    localparam int OP  = 4;
    localparam int N   = OP * OP;
    localparam int CH  = 3;
    localparam int W   = 16 * N;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic         busy;
    logic [1:0]   ch_sel;
    logic         eng_rst;
    logic         eng_done = 1'b0;
    logic [W-1:0] eng_ik1, eng_ik2, eng_ik3;
    logic [W-1:0] fm1, fm2, fm3;
    logic         fm_valid;
    logic         fm_ready;
    logic         err;

    int n_assert = 0;
    int n_fail   = 0;

    logic [15:0] tbl [CH][3][N];

    partial_fm_scheduler #(.OP_SIZE(OP), .IN_CH(CH), .CH_W(2), .ACC_W(18), .TIMEOUT(256)) dut (
        .clk(clk), .rst(rst), .start(start), .busy(busy), .ch_sel(ch_sel),
        .eng_rst(eng_rst), .eng_done(eng_done),
        .eng_ik1(eng_ik1), .eng_ik2(eng_ik2), .eng_ik3(eng_ik3),
        .fm1(fm1), .fm2(fm2), .fm3(fm3),
        .fm_valid(fm_valid), .fm_ready(fm_ready), .err(err)
    );

    always #5 clk = ~clk;

    // Input mux: the channel's partial maps are presented while ch_sel selects it.
    always_comb begin
        eng_ik1 = '0;
        eng_ik2 = '0;
        eng_ik3 = '0;
        if (ch_sel < 2'(CH)) begin
            for (int k = 0; k < N; k++) begin
                eng_ik1[16*k +: 16] = tbl[ch_sel][0][k];
                eng_ik2[16*k +: 16] = tbl[ch_sel][1][k];
                eng_ik3[16*k +: 16] = tbl[ch_sel][2][k];
            end
        end
    end

    // Engine model: done rises eng_dly cycles after release, clears while held in reset.
    int eng_cnt = 0;
    int eng_dly = 40;
    bit eng_hang = 1'b0;
    always @(posedge clk) begin
        if (eng_rst) begin
            eng_cnt  <= 0;
            eng_done <= 1'b0;
        end else if (!eng_hang) begin
            if (eng_cnt >= eng_dly - 1) eng_done <= 1'b1;
            else                        eng_cnt  <= eng_cnt + 1;
        end
    end

    int   ch_seq[$];
    int   valid_rises = 0;
    logic prev_eng_rst = 1'b1;
    logic prev_valid = 1'b0;
    always @(negedge clk) begin
        if (prev_eng_rst && !eng_rst) ch_seq.push_back(int'(ch_sel));
        if (!prev_valid && fm_valid) valid_rises++;
        prev_eng_rst = eng_rst;
        prev_valid   = fm_valid;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] ref_fm(input int j, input int k);
        int s = 0;
        for (int c = 0; c < CH; c++) s += int'($signed(tbl[c][j][k]));
        if (s > 32767)  return 16'h7FFF;
        if (s < -32768) return 16'h8000;
        return 16'(s);
    endfunction

    task automatic fill_ch(input int c, input logic [15:0] v);
        for (int j = 0; j < 3; j++)
            for (int k = 0; k < N; k++) tbl[c][j][k] = v;
    endtask

    task automatic fill_all(input logic [15:0] v);
        for (int c = 0; c < CH; c++) fill_ch(c, v);
    endtask

    task automatic fill_rand(input bit full);
        for (int c = 0; c < CH; c++)
            for (int j = 0; j < 3; j++)
                for (int k = 0; k < N; k++)
                    tbl[c][j][k] = full ? 16'($urandom) : 16'($urandom_range(0, 8191)) - 16'd4096;
    endtask

    task automatic check_fm(input string tag);
        for (int j = 0; j < 3; j++)
            for (int k = 0; k < N; k++) begin
                logic [15:0] obs;
                obs = (j == 0) ? fm1[16*k +: 16] : (j == 1) ? fm2[16*k +: 16] : fm3[16*k +: 16];
                chk($sformatf("%s_fm%0d[%0d]", tag, j + 1, k), 32'(obs), 32'(ref_fm(j, k)));
            end
    endtask

    task automatic wait_valid(input string tag);
        int t = 0;
        while (!fm_valid && t < 5000) begin
            @(negedge clk);
            t++;
        end
        chk({tag, "_valid_seen"}, 32'(fm_valid), 32'd1);
    endtask

    task automatic issue_start(input string tag);
        ch_seq.delete();
        valid_rises = 0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk({tag, "_busy_after_start"}, 32'(busy), 32'd1);
        chk({tag, "_eng_rst_released"}, 32'(eng_rst), 32'd0);
    endtask

    task automatic handshake(input string tag);
        fm_ready = 1'b1;
        @(negedge clk);
        fm_ready = 1'b0;
        chk({tag, "_valid_dropped"}, 32'(fm_valid), 32'd0);
        chk({tag, "_busy_dropped"}, 32'(busy), 32'd0);
        chk({tag, "_eng_rst_idle"}, 32'(eng_rst), 32'd1);
        chk({tag, "_valid_once"}, 32'(valid_rises), 32'd1);
    endtask

    task automatic run(input string tag, input int hold, input bit ready_early);
        fm_ready = ready_early;
        issue_start(tag);
        wait_valid(tag);
        check_fm(tag);
        for (int i = 0; i < CH; i++)
            chk($sformatf("%s_ch_seq%0d", tag, i), (i < ch_seq.size()) ? 32'(ch_seq[i]) : 32'hFFFF, 32'(i));
        for (int i = 0; i < hold; i++) begin
            start = (i == 5 || i == 12);
            @(negedge clk);
            chk($sformatf("%s_hold_valid%0d", tag, i), 32'(fm_valid), 32'd1);
            chk($sformatf("%s_hold_busy%0d", tag, i), 32'(busy), 32'd1);
        end
        start = 1'b0;
        if (hold > 0) check_fm({tag, "_held"});
        handshake(tag);
    endtask

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "bench time limit");
    end

    initial begin
        rst = 1'b1; start = 1'b0; fm_ready = 1'b0;
        fill_all(16'h0000);
        repeat (3) @(negedge clk);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_ch_sel", 32'(ch_sel), 32'd0);
        chk("rst_eng_rst", 32'(eng_rst), 32'd1);
        chk("rst_fm_valid", 32'(fm_valid), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_fm1", 32'(fm1[15:0]), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Basic run; fm_ready held high beforehand is ignored until valid.
        eng_dly = 40;
        fill_all(16'h1000);
        run("basic", 0, 1'b1);

        fill_all(16'h6000);
        run("sat_pos", 0, 1'b0);
        fill_all(16'hA000);
        run("sat_neg", 0, 1'b0);
        fill_ch(0, 16'h7000); fill_ch(1, 16'h9000); fill_ch(2, 16'h0001);
        run("mixed", 0, 1'b0);

        eng_dly = 7;
        fill_rand(1'b0);
        run("backpressure", 20, 1'b0);

        // Back-to-back: issued the cycle after return to IDLE.
        fill_all(16'h0800);
        run("b2b", 0, 1'b0);

        for (int r = 0; r < 4; r++) begin
            eng_dly = int'($urandom_range(1, 30));
            fill_rand(r[0]);
            run($sformatf("rand%0d", r), 0, 1'b0);
        end

        // Reset in ACCUM of channel 1, then a clean run with new data.
        begin
            int t = 0;
            eng_dly = 10;
            fill_all(16'h2222);
            issue_start("midrst");
            while (!(ch_sel == 2'd1 && eng_done) && t < 2000) begin
                @(negedge clk);
                t++;
            end
            chk("midrst_reached_ch1", 32'(ch_sel == 2'd1 && eng_done), 32'd1);
            repeat (6) @(negedge clk);
            rst = 1'b1;
            #2;
            chk("midrst_busy", 32'(busy), 32'd0);
            chk("midrst_eng_rst", 32'(eng_rst), 32'd1);
            chk("midrst_valid", 32'(fm_valid), 32'd0);
            chk("midrst_ch_sel", 32'(ch_sel), 32'd0);
            chk("midrst_fm1_0", 32'(fm1[15:0]), 32'd0);
            chk("midrst_fm3_15", 32'(fm3[16*15 +: 16]), 32'd0);
            @(negedge clk);
            rst = 1'b0;
            @(negedge clk);
            fill_rand(1'b0);
            run("post_rst", 0, 1'b0);
        end

`ifdef SCHED_TIMEOUT_EN
        begin
            int cnt = 0;
            eng_hang = 1'b1;
            issue_start("wd");
            while (busy && cnt < 1000) begin
                @(negedge clk);
                cnt++;
            end
            chk("wd_cycles", 32'(cnt), 32'd256);
            chk("wd_err", 32'(err), 32'd1);
            chk("wd_eng_rst", 32'(eng_rst), 32'd1);
            eng_hang = 1'b0;
            fill_all(16'h0400);
            issue_start("wd_clear");
            chk("wd_err_cleared", 32'(err), 32'd0);
            wait_valid("wd_clear");
            check_fm("wd_clear");
            handshake("wd_clear");
        end
`else
        begin
            eng_hang = 1'b1;
            fill_all(16'h0400);
            issue_start("stall");
            repeat (300) @(negedge clk);
            chk("stall_busy", 32'(busy), 32'd1);
            chk("stall_err", 32'(err), 32'd0);
            chk("stall_no_valid", 32'(fm_valid), 32'd0);
            eng_hang = 1'b0;
            wait_valid("stall");
            check_fm("stall");
            handshake("stall");
        end
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
